// File: rtl/as608_pkg.sv
// Shared constants and types for the AS608 sensor packet receiver.
package as608_pkg;

    // Two-byte packet header.
    localparam logic [7:0] HDR_BYTE1 = 8'hEF;
    localparam logic [7:0] HDR_BYTE2 = 8'h01;

    // Packet identifiers.
    localparam logic [7:0] PID_CMD  = 8'h01;
    localparam logic [7:0] PID_DATA = 8'h02;
    localparam logic [7:0] PID_ACK  = 8'h07;
    localparam logic [7:0] PID_END  = 8'h08;

    // LEN counts payload plus the two checksum bytes.
    localparam logic [15:0] LEN_MIN = 16'd2;
    localparam logic [15:0] LEN_MAX = 16'd258;

    typedef enum logic [2:0] {
        StIdle,
        StHdr2,
        StAddr,
        StPid,
        StLen,
        StPayload,
        StSum
    } state_e;

    // Packets whose payload lands in the fingerprint store.
    function automatic logic is_ram_pid(input logic [7:0] pid);
        return (pid == PID_DATA) || (pid == PID_END);
    endfunction

endpackage

// File: rtl/as608_word_pack.sv
// Packs payload bytes into 256-bit store words, first byte in the top lane.
// Emits a registered write strobe with the current address, then advances it.
module as608_word_pack (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_start,
    input  logic         drop,
    input  logic         byte_valid,
    input  logic [7:0]   byte_in,
    input  logic         flush,
    output logic         ram_we,
    output logic [7:0]   ram_add,
    output logic [255:0] ram_data,
    output logic         ram_ovf
);

    localparam logic [4:0] LAST_BYTE = 5'd31;

    logic [255:0] buf_q, buf_d, word;
    logic [4:0]   cnt_q, cnt_d;
    logic         we_q, we_d;
    logic [255:0] data_q, data_d;
    logic [7:0]   add_q, add_d;
    logic         ovf_q, ovf_d;
    logic [7:0]   lo;

    // Next word contents, write strobe, address advance and overflow flag.
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        we_d   = 1'b0;
        data_d = data_q;
        add_d  = add_q;
        ovf_d  = ovf_q;
        // Byte n of a word sits at bit 8*(31-n); 31-n is the bitwise inverse.
        lo     = {~cnt_q, 3'b000};
        word   = buf_q;
        word[lo +: 8] = byte_in;

        if (we_q) begin
            add_d = add_q + 8'd1;
            if (add_q == 8'hFF) begin
                ovf_d = 1'b1;
            end
        end

        if (byte_valid) begin
            if (cnt_q == LAST_BYTE) begin
                we_d   = 1'b1;
                data_d = word;
                buf_d  = '0;
                cnt_d  = '0;
            end else begin
                buf_d = word;
                cnt_d = cnt_q + 5'd1;
            end
        end else if (flush && (cnt_q != 5'd0)) begin
            // Unfilled lanes are already zero, giving the pad for free.
            we_d   = 1'b1;
            data_d = buf_q;
            buf_d  = '0;
            cnt_d  = '0;
        end

        if (drop || frame_start) begin
            buf_d = '0;
            cnt_d = '0;
        end
        if (frame_start) begin
            add_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Packing state and store interface registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            data_q <= '0;
            add_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            data_q <= data_d;
            add_q  <= add_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ram_we   = we_q;
    assign ram_add  = add_q;
    assign ram_data = data_q;
    assign ram_ovf  = ovf_q;

endmodule

// File: rtl/as608_pkt_rx.sv
// AS608 packet receiver: header/address/PID/LEN/payload/checksum parser with an
// inter-byte timeout. Define AS608_ADDR_CHECK_EN to reject packets whose
// address differs from AS608_ADDR.
module as608_pkt_rx
    import as608_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 250000,
    parameter logic [31:0] AS608_ADDR  = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         frame_start,
    output logic         ram_we,
    output logic [7:0]   ram_add,
    output logic [255:0] ram_data,
    output logic         pkt_done,
    output logic         pkt_err,
    output logic [7:0]   pkt_pid,
    output logic [7:0]   ack_code,
    output logic         ram_ovf
);

    localparam int unsigned     TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d, cur_state;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [15:0]   pay_cnt_q, pay_cnt_d;
    logic [7:0]    pid_q, pid_d;
    logic [15:0]   sum_q, sum_d;
    logic [7:0]    sum_hi_q, sum_hi_d;
    logic [7:0]    shadow_q, shadow_d;
    logic          ack_first_q, ack_first_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    pkt_pid_q, pkt_pid_d;
    logic [7:0]    ack_code_q, ack_code_d;
    logic [15:0]   len_word;
    logic          pack_valid, pack_flush, pack_drop;
`ifdef AS608_ADDR_CHECK_EN
    logic [23:0]   addr_q, addr_d;
`endif

    // Parser next state, checksum, timeout and result pulses.
    always_comb begin
        // frame_start aborts first, so a same-cycle byte is seen from IDLE.
        cur_state   = frame_start ? StIdle : state_q;
        state_d     = cur_state;
        idx_d       = idx_q;
        len_hi_d    = len_hi_q;
        pay_cnt_d   = pay_cnt_q;
        pid_d       = pid_q;
        sum_d       = sum_q;
        sum_hi_d    = sum_hi_q;
        shadow_d    = shadow_q;
        ack_first_d = ack_first_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pkt_pid_d   = pkt_pid_q;
        ack_code_d  = ack_code_q;
        pack_valid  = 1'b0;
        pack_flush  = 1'b0;
        pack_drop   = 1'b0;
        len_word    = {len_hi_q, rx_data};
`ifdef AS608_ADDR_CHECK_EN
        addr_d      = addr_q;
`endif
        timer_d     = (rx_valid || cur_state == StIdle) ? '0 : timer_q + 1'b1;

        if (!rx_valid && cur_state != StIdle && timer_q == TIMER_LAST) begin
            err_d     = 1'b1;
            state_d   = StIdle;
            pack_drop = 1'b1;
            timer_d   = '0;
        end else if (rx_valid) begin
            unique case (cur_state)
                StIdle: begin
                    if (rx_data == HDR_BYTE1) state_d = StHdr2;
                end
                StHdr2: begin
                    if (rx_data == HDR_BYTE2) begin
                        state_d = StAddr;
                        idx_d   = 2'd0;
                    end else if (rx_data != HDR_BYTE1) begin
                        state_d = StIdle;
                    end
                end
                StAddr: begin
`ifdef AS608_ADDR_CHECK_EN
                    addr_d = {addr_q[15:0], rx_data};
`endif
                    if (idx_q == 2'd3) begin
`ifdef AS608_ADDR_CHECK_EN
                        if ({addr_q, rx_data} != AS608_ADDR) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StPid;
                        end
`else
                        state_d = StPid;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                StPid: begin
                    pid_d   = rx_data;
                    sum_d   = {8'h00, rx_data};
                    state_d = StLen;
                    idx_d   = 2'd0;
                end
                StLen: begin
                    sum_d = sum_q + {8'h00, rx_data};
                    if (idx_q == 2'd0) begin
                        len_hi_d = rx_data;
                        idx_d    = 2'd1;
                    end else if (len_word < LEN_MIN || len_word > LEN_MAX) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        pay_cnt_d   = len_word - LEN_MIN;
                        shadow_d    = 8'h00;
                        ack_first_d = 1'b1;
                        idx_d       = 2'd0;
                        state_d     = (len_word == LEN_MIN) ? StSum : StPayload;
                    end
                end
                StPayload: begin
                    sum_d      = sum_q + {8'h00, rx_data};
                    pack_valid = is_ram_pid(pid_q);
                    if (pid_q == PID_ACK && ack_first_q) begin
                        shadow_d    = rx_data;
                        ack_first_d = 1'b0;
                    end
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    if (pay_cnt_q == 16'd1) begin
                        state_d = StSum;
                        idx_d   = 2'd0;
                    end
                end
                StSum: begin
                    if (idx_q == 2'd0) begin
                        sum_hi_d = rx_data;
                        idx_d    = 2'd1;
                    end else begin
                        state_d = StIdle;
                        if ({sum_hi_q, rx_data} == sum_q) begin
                            done_d     = 1'b1;
                            pkt_pid_d  = pid_q;
                            pack_flush = (pid_q == PID_END);
                            if (pid_q == PID_ACK) ack_code_d = shadow_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Parser state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            len_hi_q    <= '0;
            pay_cnt_q   <= '0;
            pid_q       <= '0;
            sum_q       <= '0;
            sum_hi_q    <= '0;
            shadow_q    <= '0;
            ack_first_q <= 1'b0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pkt_pid_q   <= '0;
            ack_code_q  <= '0;
`ifdef AS608_ADDR_CHECK_EN
            addr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_hi_q    <= len_hi_d;
            pay_cnt_q   <= pay_cnt_d;
            pid_q       <= pid_d;
            sum_q       <= sum_d;
            sum_hi_q    <= sum_hi_d;
            shadow_q    <= shadow_d;
            ack_first_q <= ack_first_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pkt_pid_q   <= pkt_pid_d;
            ack_code_q  <= ack_code_d;
`ifdef AS608_ADDR_CHECK_EN
            addr_q      <= addr_d;
`endif
        end
    end

    as608_word_pack u_word_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .drop        (pack_drop),
        .byte_valid  (pack_valid),
        .byte_in     (rx_data),
        .flush       (pack_flush),
        .ram_we      (ram_we),
        .ram_add     (ram_add),
        .ram_data    (ram_data),
        .ram_ovf     (ram_ovf)
    );

    assign pkt_done = done_q;
    assign pkt_err  = err_q;
    assign pkt_pid  = pkt_pid_q;
    assign ack_code = ack_code_q;

endmodule
